// File: rtl/snn_layer_scheduler.sv
// snn_layer_scheduler
//   Time-multiplexes N_NEURONS leaky integrate-and-fire neurons onto one
//   shared update datapath. A timestep latches the input spike vector, then
//   updates one neuron per cycle (leak, integrate, saturate, fire/reset),
//   and publishes the resulting spike vector with a one-cycle done pulse.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   ena             1 = run; 0 = freeze all state (start/cfg_we ignored)
//   start           begin a timestep (only honoured in IDLE)
//   in_spikes       per-neuron input spikes, latched on the accepted start
//   cfg_we/addr/data configuration write (IDLE only):
//                   0..7 weight[i], 8 threshold, 9 leak_shift[2:0]
//   busy            high while a timestep is in flight (UPDATE, DONE)
//   done            one-cycle pulse, coincident with out_spikes update
//   out_spikes      spike vector of the last completed timestep
//   cur_idx         neuron currently being updated (0 outside UPDATE)
module snn_layer_scheduler #(
   parameter int N_NEURONS = 8,
   parameter int W         = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 start,
   input  logic [N_NEURONS-1:0] in_spikes,
   input  logic                 cfg_we,
   input  logic [3:0]           cfg_addr,
   input  logic [W-1:0]         cfg_data,
   output logic                 busy,
   output logic                 done,
   output logic [N_NEURONS-1:0] out_spikes,
   output logic [2:0]           cur_idx
);

   typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_e;

   localparam logic [2:0]   LAST_IDX = 3'(N_NEURONS - 1);
   localparam logic [W-1:0] THR_RST  = W'(8'h80);

   state_e                      state_q, state_d;
   logic [2:0]                  idx_q, idx_d;
   logic [N_NEURONS-1:0]        spk_lat_q;
   logic [N_NEURONS-1:0]        shadow_q;
   logic [N_NEURONS-1:0]        out_q;
   logic                        done_q;
   logic [N_NEURONS-1:0][W-1:0] v_q;
   logic [N_NEURONS-1:0][W-1:0] weight_q;
   logic [W-1:0]                thr_q;
   logic [2:0]                  leak_sh_q;

   // ---------------- shared neuron datapath ----------------
   logic [W-1:0] v_cur, leak, w_cur, sat;
   logic [W:0]   sum;
   logic         fire;

   always_comb begin
      v_cur = v_q[idx_q];
      // shift of 0 means "no leak", not "leak everything"
      leak  = (leak_sh_q == 3'd0) ? '0 : (v_cur >> leak_sh_q);
      w_cur = spk_lat_q[idx_q] ? weight_q[idx_q] : '0;
      // v - leak never underflows, so one extra bit catches the only overflow
      sum   = {1'b0, v_cur} - {1'b0, leak} + {1'b0, w_cur};
      sat   = sum[W] ? '1 : sum[W-1:0];
      fire  = (sat >= thr_q);
   end

   // ---------------- control FSM ----------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_UPDATE;
               idx_d   = 3'd0;
            end
         end
         S_UPDATE: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
               idx_d   = 3'd0;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: begin
            state_d = S_IDLE;
            idx_d   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= 3'd0;
      end else if (ena) begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // ---------------- state / configuration ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spk_lat_q <= '0;
         shadow_q  <= '0;
         out_q     <= '0;
         v_q       <= '0;
         weight_q  <= '0;
         thr_q     <= THR_RST;
         leak_sh_q <= 3'd0;
      end else if (ena) begin
         unique case (state_q)
            S_IDLE: begin
               // a write in the start cycle lands before the first update
               if (cfg_we) begin
                  if (cfg_addr == 4'd8)
                     thr_q <= cfg_data;
                  else if (cfg_addr == 4'd9)
                     leak_sh_q <= cfg_data[2:0];
                  else if (int'(cfg_addr) < N_NEURONS)
                     weight_q[cfg_addr[2:0]] <= cfg_data;
               end
               if (start) begin
                  spk_lat_q <= in_spikes;
                  shadow_q  <= '0;
               end
            end
            S_UPDATE: begin
               v_q[idx_q] <= fire ? '0 : sat;
               if (fire) shadow_q[idx_q] <= 1'b1;
            end
            S_DONE: out_q <= shadow_q;
            default: ;
         endcase
      end
   end

   // done rises together with out_spikes; gated by ena so a freeze
   // can never stretch it beyond one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) done_q <= 1'b0;
      else        done_q <= ena && (state_q == S_DONE);
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign out_spikes = out_q;
   assign cur_idx    = idx_q;

endmodule
